// File: rtl/acc_wbuffer_if.sv
// ---------------------------------------------------------------------------
// acc_wbuffer_if
// Bundles the result-row handshake from the MAC array, the tile controller
// handshake and the output-memory bus of the write-back accumulation buffer.
//   slave  : the buffer itself (accepts rows, drives the memory bus)
//   master : the surrounding controller / memory side
// Signals:
//   ROW_VALID, ROW_DATA, ODST, ACC, ROW_TOTAL : result rows + tile info
//   OMSRC                                     : output-memory bus ownership
//   MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA       : memory request side
//   MEM_RDATA                                 : read data, 1 cycle after RE
//   INIT_DONE, LOAD_DONE, STORE_DONE, OVF     : status back to controller
// ---------------------------------------------------------------------------
interface acc_wbuffer_if #(
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int AW    = 4
);
  logic                  ROW_VALID;
  logic [LANES*DW-1:0]   ROW_DATA;
  logic [AW-1:0]         ODST;
  logic                  ACC;
  logic [2:0]            ROW_TOTAL;
  logic                  OMSRC;
  logic [LANES*DW-1:0]   MEM_RDATA;
  logic [AW-1:0]         MEM_ADDR;
  logic                  MEM_RE;
  logic                  MEM_WE;
  logic [LANES*DW-1:0]   MEM_WDATA;
  logic                  INIT_DONE;
  logic                  LOAD_DONE;
  logic                  STORE_DONE;
  logic                  OVF;

  modport slave (
    input  ROW_VALID, ROW_DATA, ODST, ACC, ROW_TOTAL, OMSRC, MEM_RDATA,
    output MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA,
    output INIT_DONE, LOAD_DONE, STORE_DONE, OVF
  );

  modport master (
    output ROW_VALID, ROW_DATA, ODST, ACC, ROW_TOTAL, OMSRC, MEM_RDATA,
    input  MEM_ADDR, MEM_RE, MEM_WE, MEM_WDATA,
    input  INIT_DONE, LOAD_DONE, STORE_DONE, OVF
  );
endinterface

// File: rtl/acc_wbuffer.sv
// ---------------------------------------------------------------------------
// acc_wbuffer
// Write-back accumulation buffer behind the 4x4 MAC array.
//  - After reset, zero-fills all 2^AW output-memory rows (one per cycle) and
//    raises the sticky INIT_DONE.
//  - In an accumulate pass (ACC=1) collects up to DEPTH result rows with
//    their destination addresses, then raises LOAD_DONE.
//  - Once it owns the bus (OMSRC=1) it read-modify-writes every row
//    (memory + row, lane-wise modulo 2^DW) at two cycles per row and pulses
//    STORE_DONE on the final write.
//  - Rows offered while it cannot accept them are dropped and set sticky OVF.
// Ports:
//   CLK : clock, rising edge
//   RST : synchronous active-high reset, dominates everything
//   bus : acc_wbuffer_if.slave (row input, controller handshake, memory bus)
// ---------------------------------------------------------------------------
module acc_wbuffer #(
  parameter int DW    = 8,
  parameter int LANES = 4,
  parameter int AW    = 4,
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  acc_wbuffer_if.slave bus
);

  localparam int RW = LANES * DW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Row counts share the 3-bit width of ROW_TOTAL.
  localparam logic [2:0]    DEPTH_C = 3'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [IW-1:0] IDX_ONE = {{(IW-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_INIT    = 3'd0,
    S_COLLECT = 3'd1,
    S_FULL    = 3'd2,
    S_RD      = 3'd3,
    S_WR      = 3'd4
  } state_t;

  // Lane-wise add: each DW-bit lane wraps on its own, no carry between lanes.
  function automatic logic [RW-1:0] lane_add(input logic [RW-1:0] a,
                                             input logic [RW-1:0] b);
    logic [RW-1:0] sum;
    sum = {RW{1'b0}};
    for (int l = 0; l < LANES; l++) begin
      sum[l*DW +: DW] = a[l*DW +: DW] + b[l*DW +: DW];
    end
    return sum;
  endfunction

  state_t        state_r;
  logic [AW:0]   init_cnt_r;   // extra MSB marks "last address presented"
  logic [2:0]    rows_r;
  logic [2:0]    total_r;
  logic [IW-1:0] idx_r;
  logic [AW-1:0] slot_addr_r [DEPTH];
  logic [RW-1:0] slot_data_r [DEPTH];

  logic [AW-1:0] mem_addr_r;
  logic          mem_re_r;
  logic          mem_we_r;
  logic          init_done_r;
  logic          load_done_r;
  logic          store_done_r;
  logic          ovf_r;

  logic          accept_s;
  logic [2:0]    tot_clamp_s;
  logic [2:0]    eff_total_s;
  logic [2:0]    rows_inc_s;
  logic          last_s;
  logic [IW-1:0] idx_nxt_s;
  logic [RW-1:0] wdata_s;

  assign accept_s   = bus.ROW_VALID & bus.ACC;
  assign rows_inc_s = rows_r + 3'd1;
  assign idx_nxt_s  = idx_r + IDX_ONE;
  assign last_s     = ((3'(idx_r) + 3'd1) == total_r);

  // Clamp the tile row count: 0 or anything above DEPTH means a full tile.
  always_comb begin
    tot_clamp_s = DEPTH_C;
    if ((bus.ROW_TOTAL == 3'd0) || (bus.ROW_TOTAL > DEPTH_C)) begin
      tot_clamp_s = DEPTH_C;
    end else begin
      tot_clamp_s = bus.ROW_TOTAL;
    end
  end

  // The first row of a tile uses the live (clamped) total; later rows the latched one.
  always_comb begin
    eff_total_s = total_r;
    if (rows_r == 3'd0) begin
      eff_total_s = tot_clamp_s;
    end else begin
      eff_total_s = total_r;
    end
  end

  // Read data lands in the write cycle itself, so the sum is formed from
  // registered state plus MEM_RDATA; it is forced to 0 whenever WE is low.
  always_comb begin
    wdata_s = {RW{1'b0}};
    if (state_r == S_WR) begin
      wdata_s = lane_add(bus.MEM_RDATA, slot_data_r[idx_r]);
    end else begin
      wdata_s = {RW{1'b0}};
    end
  end

  // Slot storage: capture {ODST, ROW_DATA} of every accepted row while collecting.
  always_ff @(posedge CLK) begin
    if (!RST && (state_r == S_COLLECT) && accept_s) begin
      slot_addr_r[rows_r[IW-1:0]] <= bus.ODST;
      slot_data_r[rows_r[IW-1:0]] <= bus.ROW_DATA;
    end
  end

  // Sticky overflow: a row offered in any state that cannot take it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_r <= 1'b0;
    end else if (accept_s && (state_r != S_COLLECT)) begin
      ovf_r <= 1'b1;
    end
  end

  // Main FSM; outputs are loaded together with the state they belong to.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r      <= S_INIT;
      init_cnt_r   <= {(AW+1){1'b0}};
      rows_r       <= 3'd0;
      total_r      <= 3'd0;
      idx_r        <= {IW{1'b0}};
      mem_addr_r   <= {AW{1'b0}};
      mem_re_r     <= 1'b0;
      mem_we_r     <= 1'b0;
      init_done_r  <= 1'b0;
      load_done_r  <= 1'b0;
      store_done_r <= 1'b0;
    end else begin
      case (state_r)
        S_INIT: begin
          if (init_cnt_r[AW] == 1'b0) begin
            mem_we_r   <= 1'b1;
            mem_addr_r <= init_cnt_r[AW-1:0];
            init_cnt_r <= init_cnt_r + CNT_ONE;
          end else begin
            // Last address is being written on this edge.
            mem_we_r    <= 1'b0;
            mem_addr_r  <= {AW{1'b0}};
            init_done_r <= 1'b1;
            state_r     <= S_COLLECT;
          end
        end

        S_COLLECT: begin
          if (accept_s) begin
            rows_r <= rows_inc_s;
            if (rows_r == 3'd0) begin
              total_r <= tot_clamp_s;
            end
            if (rows_inc_s == eff_total_s) begin
              load_done_r <= 1'b1;
              state_r     <= S_FULL;
            end
          end
        end

        S_FULL: begin
          if (bus.OMSRC) begin
            load_done_r <= 1'b0;
            idx_r       <= {IW{1'b0}};
            mem_re_r    <= 1'b1;
            mem_addr_r  <= slot_addr_r[0];
            state_r     <= S_RD;
          end
        end

        S_RD: begin
          mem_re_r     <= 1'b0;
          mem_we_r     <= 1'b1;
          mem_addr_r   <= slot_addr_r[idx_r];
          store_done_r <= last_s;
          state_r      <= S_WR;
        end

        S_WR: begin
          mem_we_r <= 1'b0;
          if (last_s) begin
            store_done_r <= 1'b0;
            mem_addr_r   <= {AW{1'b0}};
            rows_r       <= 3'd0;
            total_r      <= 3'd0;
            idx_r        <= {IW{1'b0}};
            state_r      <= S_COLLECT;
          end else begin
            // Next row's read follows this write, so duplicate ODSTs chain.
            idx_r      <= idx_nxt_s;
            mem_re_r   <= 1'b1;
            mem_addr_r <= slot_addr_r[idx_nxt_s];
            state_r    <= S_RD;
          end
        end

        default: begin
          state_r      <= S_INIT;
          init_cnt_r   <= {(AW+1){1'b0}};
          rows_r       <= 3'd0;
          total_r      <= 3'd0;
          idx_r        <= {IW{1'b0}};
          mem_addr_r   <= {AW{1'b0}};
          mem_re_r     <= 1'b0;
          mem_we_r     <= 1'b0;
          init_done_r  <= 1'b0;
          load_done_r  <= 1'b0;
          store_done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.MEM_ADDR   = mem_addr_r;
  assign bus.MEM_RE     = mem_re_r;
  assign bus.MEM_WE     = mem_we_r;
  assign bus.MEM_WDATA  = wdata_s;
  assign bus.INIT_DONE  = init_done_r;
  assign bus.LOAD_DONE  = load_done_r;
  assign bus.STORE_DONE = store_done_r;
  assign bus.OVF        = ovf_r;

endmodule

// File: tb/tb_acc_wbuffer.sv
// ---------------------------------------------------------------------------
// tb_acc_wbuffer
// Directed bench for acc_wbuffer with a small output-memory model.
// Inputs change on the falling edge; outputs are compared on the falling
// edge after the rising edge that the vector was applied to.
// ---------------------------------------------------------------------------
module tb_acc_wbuffer;

  localparam logic [31:0] Z  = 32'h0000_0000;
  localparam logic [31:0] D  = 32'h0102_0304;
  localparam logic [31:0] DA = 32'h1020_3040;
  localparam logic [31:0] DB = 32'h7F80_FF01;
  localparam logic [31:0] DC = 32'h0000_0001;
  localparam logic [31:0] DD = 32'h8080_8080;
  localparam logic [31:0] DE = 32'h1122_3344;

  typedef struct packed {
    logic        rst, rv, acc, oms, pre;
    logic [3:0]  odst;
    logic [31:0] data;
    logic [2:0]  tot;
    logic        re, we;
    logic [3:0]  addr;
    logic [31:0] wd;
    logic        ld, sd, ovf, idone;
  } vec_t;

  logic clk;
  logic rst;
  logic        pre_we;
  logic [3:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [16];
  logic [31:0] rdata_r;

  int n_chk  = 0;
  int n_pass = 0;
  vec_t vq[$];

  acc_wbuffer_if #(.DW(8), .LANES(4), .AW(4)) bus ();

  acc_wbuffer #(.DW(8), .LANES(4), .AW(4), .DEPTH(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output memory: synchronous write, read data valid the cycle after RE.
  always @(posedge clk) begin
    if (bus.MEM_WE) mem[bus.MEM_ADDR] <= bus.MEM_WDATA;
    else if (pre_we) mem[pre_addr] <= pre_data;
    if (bus.MEM_RE) rdata_r <= mem[bus.MEM_ADDR];
  end
  assign bus.MEM_RDATA = rdata_r;

  function automatic vec_t mkv(input int rst_i, input int rv, input int acc,
                               input int oms, input int pre, input int odst,
                               input logic [31:0] data, input int tot,
                               input int re, input int we, input int addr,
                               input logic [31:0] wd, input int ld,
                               input int sd, input int ovf, input int idone);
    vec_t v;
    v.rst = 1'(rst_i); v.rv = 1'(rv); v.acc = 1'(acc); v.oms = 1'(oms);
    v.pre = 1'(pre); v.odst = 4'(odst); v.data = data; v.tot = 3'(tot);
    v.re = 1'(re); v.we = 1'(we); v.addr = 4'(addr); v.wd = wd;
    v.ld = 1'(ld); v.sd = 1'(sd); v.ovf = 1'(ovf); v.idone = 1'(idone);
    return v;
  endfunction

  task automatic chk_out(input string nm, input int id, input int re,
                         input int we, input int addr, input logic [31:0] wd,
                         input int ld, input int sd, input int ovf,
                         input int idone);
    logic [41:0] got, want;
    got  = {bus.MEM_RE, bus.MEM_WE, bus.MEM_ADDR, bus.MEM_WDATA,
            bus.LOAD_DONE, bus.STORE_DONE, bus.OVF, bus.INIT_DONE};
    want = {1'(re), 1'(we), 4'(addr), wd, 1'(ld), 1'(sd), 1'(ovf), 1'(idone)};
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s[%0d] re,we,addr,wdata,ld,sd,ovf,idone got %b %b %h %h %b %b %b %b required %b %b %h %h %b %b %b %b",
                  nm, id, got[41], got[40], got[39:36], got[35:4], got[3], got[2], got[1], got[0],
                  want[41], want[40], want[39:36], want[35:4], want[3], want[2], want[1], want[0]);
  endtask

  task automatic chk_mem(input int a, input logic [31:0] want);
    n_chk++;
    if (mem[a] === want) n_pass++;
    else $display("FAIL mem[%0d] got %h required %h", a, mem[a], want);
  endtask

  // Zero-fill check from address 'first' onward, then INIT_DONE.
  task automatic check_init(input int first);
    for (int k = first; k < 16; k++) begin
      @(negedge clk);
      chk_out("init", k, 0, 1, k, Z, 0, 0, 0, 0);
    end
    @(negedge clk);
    chk_out("init_done", 16, 0, 0, 0, Z, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1'b1; pre_we = 1'b0; pre_addr = 4'd0; pre_data = 32'hFF00_00FF;
    bus.ROW_VALID = 1'b0; bus.ROW_DATA = Z; bus.ODST = 4'd0; bus.ACC = 1'b0;
    bus.ROW_TOTAL = 3'd0; bus.OMSRC = 1'b1;

    // rst, rv, acc, oms, pre, odst, data, tot, re, we, addr, wdata, ld, sd, ovf, idone
    // Full tile of 4 rows into zeroed memory.
    vq.push_back(mkv(0,1,1,0,0, 0,D,4,  0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 1,D,4,  0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 2,D,4,  0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 3,D,4,  0,0,0,Z, 1,0,0,1));
    vq.push_back(mkv(0,0,0,0,0, 0,Z,4,  0,0,0,Z, 1,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  1,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  0,1,0,D, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  1,0,1,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  0,1,1,D, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  1,0,2,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  0,1,2,D, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  1,0,3,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  0,1,3,D, 0,1,0,1));
    vq.push_back(mkv(0,0,0,0,0, 0,Z,4,  0,0,0,Z, 0,0,0,1));
    // Same tile again, addr 0 preloaded with FF0000FF: per-lane wrap.
    vq.push_back(mkv(0,1,1,0,1, 0,D,4,  0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 1,D,4,  0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 2,D,4,  0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 3,D,4,  0,0,0,Z, 1,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  1,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  0,1,0,32'h0002_0303, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  1,0,1,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  0,1,1,32'h0204_0608, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  1,0,2,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  0,1,2,32'h0204_0608, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  1,0,3,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,  0,1,3,32'h0204_0608, 0,1,0,1));
    vq.push_back(mkv(0,0,0,0,0, 0,Z,4,  0,0,0,Z, 0,0,0,1));
    // Two-row tile at 9 and 13; total latched on the first row.
    vq.push_back(mkv(0,1,1,0,0, 9,DA,2,  0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 13,DB,4, 0,0,0,Z, 1,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,   1,0,9,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,   0,1,9,DA, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,   1,0,13,Z, 0,0,0,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,4,   0,1,13,DB, 0,1,0,1));
    vq.push_back(mkv(0,0,0,0,0, 0,Z,4,   0,0,0,Z, 0,0,0,1));
    // ROW_TOTAL=0 means 4 rows; ACC=0 rows ignored; duplicate ODST 5.
    vq.push_back(mkv(0,1,0,0,0, 5,DE,0, 0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 5,DC,0, 0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 5,DC,0, 0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,0,0,0, 8,DE,0, 0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 6,DD,0, 0,0,0,Z, 0,0,0,1));
    vq.push_back(mkv(0,1,1,0,0, 7,DD,0, 0,0,0,Z, 1,0,0,1));
    // Row while FULL: dropped, OVF set, LOAD_DONE held.
    vq.push_back(mkv(0,1,1,0,0, 14,DE,0, 0,0,0,Z, 1,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,0,   1,0,5,Z, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,0,   0,1,5,DC, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,0,   1,0,5,Z, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,0,   0,1,5,32'h0000_0002, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,0,   1,0,6,Z, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,0,   0,1,6,DD, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,0,   1,0,7,Z, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,0,   0,1,7,DD, 0,1,1,1));
    vq.push_back(mkv(0,0,0,0,0, 0,Z,0,   0,0,0,Z, 0,0,1,1));
    // Three-row tile, reset during the write of row 2.
    vq.push_back(mkv(0,1,1,0,0, 10,DE,3, 0,0,0,Z, 0,0,1,1));
    vq.push_back(mkv(0,1,1,0,0, 11,DE,3, 0,0,0,Z, 0,0,1,1));
    vq.push_back(mkv(0,1,1,0,0, 12,DE,3, 0,0,0,Z, 1,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,3,   1,0,10,Z, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,3,   0,1,10,DE, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,3,   1,0,11,Z, 0,0,1,1));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,3,   0,1,11,DE, 0,0,1,1));
    vq.push_back(mkv(1,0,0,1,0, 0,Z,3,   0,0,0,Z, 0,0,0,0));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,3,   0,1,0,Z, 0,0,0,0));
    vq.push_back(mkv(0,0,0,1,0, 0,Z,3,   0,1,1,Z, 0,0,0,0));

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk_out("reset", 0, 0, 0, 0, Z, 0, 0, 0, 0);
    rst = 1'b0;
    check_init(0);

    foreach (vq[i]) begin
      rst           = vq[i].rst;
      bus.ROW_VALID = vq[i].rv;
      bus.ACC       = vq[i].acc;
      bus.OMSRC     = vq[i].oms;
      bus.ODST      = vq[i].odst;
      bus.ROW_DATA  = vq[i].data;
      bus.ROW_TOTAL = vq[i].tot;
      pre_we        = vq[i].pre;
      @(negedge clk);
      chk_out("vec", i, vq[i].re, vq[i].we, vq[i].addr, vq[i].wd,
              vq[i].ld, vq[i].sd, vq[i].ovf, vq[i].idone);
    end

    // Memory contents before the restarted zero-fill reaches them.
    chk_mem(0,  Z);
    chk_mem(3,  32'h0204_0608);
    chk_mem(5,  32'h0000_0002);
    chk_mem(9,  DA);
    chk_mem(10, DE);
    chk_mem(12, Z);
    chk_mem(13, DB);
    chk_mem(14, Z);

    // Restarted zero-fill continues from address 2 and completes.
    check_init(2);
    chk_mem(13, Z);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
